rx_payload_q_enq_engine: RTL and testbench

//  Parametrised per-flow RX payload queue enqueue engine. Accepts one payload

---
 rtl/rx_payload_q_enq_engine.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_rx_payload_q_enq_engine.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_payload_q_enq_engine.sv
`default_nettype none
// ============================================================================
// Module      : rx_payload_q_enq_engine
// Description : Per-flow RX payload queue enqueue engine. Accepts one payload
//               entry for a flow, reads that flow's head and tail pointers,
//               checks for a full queue, then writes the payload buffer and
//               the advanced tail pointer. It returns a completion carrying
//               the slot index used, or a drop flag when the queue was full.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   enq_req_*                    enqueue request (val/rdy, flowid, data)
//   enq_resp_*                   completion (val/rdy, flowid, index, dropped)
//   head_rd_req_* / _resp_*      head pointer memory read channel
//   tail_rd_req_* / _resp_*      tail pointer memory read channel
//   tail_wr_req_*                tail pointer memory write channel
//   buf_wr_req_*                 payload buffer write channel
//
// Revision    : 1.0  initial release
// ============================================================================
module rx_payload_q_enq_engine #(
    parameter int FLOW_ID_W      = 4,
    parameter int Q_SIZE_W       = 3,
    parameter int ENTRY_W        = 256,
    parameter int DROP_WHEN_FULL = 1
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          enq_req_val,
    input  logic [FLOW_ID_W-1:0]          enq_req_flowid,
    input  logic [ENTRY_W-1:0]            enq_req_data,
    output logic                          enq_req_rdy,

    output logic                          enq_resp_val,
    output logic [FLOW_ID_W-1:0]          enq_resp_flowid,
    output logic [Q_SIZE_W:0]             enq_resp_index,
    output logic                          enq_resp_dropped,
    input  logic                          enq_resp_rdy,

    output logic                          head_rd_req_val,
    output logic [FLOW_ID_W-1:0]          head_rd_req_addr,
    input  logic                          head_rd_req_rdy,
    input  logic                          head_rd_resp_val,
    input  logic [Q_SIZE_W:0]             head_rd_resp_data,
    output logic                          head_rd_resp_rdy,

    output logic                          tail_rd_req_val,
    output logic [FLOW_ID_W-1:0]          tail_rd_req_addr,
    input  logic                          tail_rd_req_rdy,
    input  logic                          tail_rd_resp_val,
    input  logic [Q_SIZE_W:0]             tail_rd_resp_data,
    output logic                          tail_rd_resp_rdy,

    output logic                          tail_wr_req_val,
    output logic [FLOW_ID_W-1:0]          tail_wr_req_addr,
    output logic [Q_SIZE_W:0]             tail_wr_req_data,
    input  logic                          tail_wr_req_rdy,

    output logic                          buf_wr_req_val,
    output logic [FLOW_ID_W+Q_SIZE_W-1:0] buf_wr_req_addr,
    output logic [ENTRY_W-1:0]            buf_wr_req_data,
    input  logic                          buf_wr_req_rdy
);

    localparam int PTR_W   = Q_SIZE_W + 1;
    localparam bit DROP_EN = (DROP_WHEN_FULL != 0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_WR      = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    // Captured request and pointer values
    logic [FLOW_ID_W-1:0] flowid_q;
    logic [ENTRY_W-1:0]   data_q;
    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic                 dropped_q;

    // Per-channel completion flags; each channel's val drops on its own
    // handshake while the sibling channel may still be stalled.
    logic head_req_done;
    logic tail_req_done;
    logic head_got;
    logic tail_got;
    logic tail_wr_done;
    logic buf_wr_done;

    logic enq_req_fire;
    logic head_req_fire;
    logic tail_req_fire;
    logic head_resp_fire;
    logic tail_resp_fire;
    logic tail_wr_fire;
    logic buf_wr_fire;
    logic enq_resp_fire;
    logic full;

    // ------------------------------------------------------------------
    // Outputs: decoded from state and completion flags only, so the
    // handshake terms below never loop back through the next-state logic.
    // ------------------------------------------------------------------
    // rst is folded in so the request port reads not-ready for the whole
    // time reset is held, not just after the state register settles.
    assign enq_req_rdy      = (state == ST_IDLE) && rst;

    assign head_rd_req_val  = (state == ST_RD_REQ) && !head_req_done;
    assign tail_rd_req_val  = (state == ST_RD_REQ) && !tail_req_done;
    assign head_rd_req_addr = flowid_q;
    assign tail_rd_req_addr = flowid_q;

    assign head_rd_resp_rdy = (state == ST_RD_RESP);
    assign tail_rd_resp_rdy = (state == ST_RD_RESP);

    assign tail_wr_req_val  = (state == ST_WR) && !tail_wr_done;
    assign tail_wr_req_addr = flowid_q;
    // Pointer is one bit wider than the slot index; the natural rollover
    // toggles the wrap bit after the last slot.
    assign tail_wr_req_data = tail_q + {{(PTR_W-1){1'b0}}, 1'b1};

    assign buf_wr_req_val   = (state == ST_WR) && !buf_wr_done;
    assign buf_wr_req_addr  = {flowid_q, tail_q[Q_SIZE_W-1:0]};
    assign buf_wr_req_data  = data_q;

    assign enq_resp_val     = (state == ST_RESP);
    assign enq_resp_flowid  = flowid_q;
    assign enq_resp_index   = tail_q;
    assign enq_resp_dropped = dropped_q;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign enq_req_fire   = enq_req_val && enq_req_rdy;
    assign head_req_fire  = head_rd_req_val && head_rd_req_rdy;
    assign tail_req_fire  = tail_rd_req_val && tail_rd_req_rdy;
    // Only the first response per channel is taken in a read round.
    assign head_resp_fire = head_rd_resp_val && head_rd_resp_rdy && !head_got;
    assign tail_resp_fire = tail_rd_resp_val && tail_rd_resp_rdy && !tail_got;
    assign tail_wr_fire   = tail_wr_req_val && tail_wr_req_rdy;
    assign buf_wr_fire    = buf_wr_req_val && buf_wr_req_rdy;
    assign enq_resp_fire  = enq_resp_val && enq_resp_rdy;

    // Same slot index but opposite wrap bits: the tail has lapped the head.
    assign full = (head_q[PTR_W-1] != tail_q[PTR_W-1]) &&
                  (head_q[Q_SIZE_W-1:0] == tail_q[Q_SIZE_W-1:0]);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enq_req_fire) begin
                    state_nxt = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if ((head_req_done || head_req_fire) &&
                    (tail_req_done || tail_req_fire)) begin
                    state_nxt = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if ((head_got || head_resp_fire) &&
                    (tail_got || tail_resp_fire)) begin
                    state_nxt = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                if (!full) begin
                    state_nxt = ST_WR;
                end else if (DROP_EN) begin
                    state_nxt = ST_RESP;
                end else begin
                    // Wait for the consumer to free a slot by re-polling.
                    state_nxt = ST_RD_REQ;
                end
            end
            ST_WR: begin
                if ((tail_wr_done || tail_wr_fire) &&
                    (buf_wr_done || buf_wr_fire)) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (enq_resp_fire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request capture and drop flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flowid_q  <= '0;
            data_q    <= '0;
            dropped_q <= 1'b0;
        end else begin
            if (enq_req_fire) begin
                flowid_q  <= enq_req_flowid;
                data_q    <= enq_req_data;
                dropped_q <= 1'b0;
            end else if ((state == ST_DECIDE) && full && DROP_EN) begin
                dropped_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointer read channels
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_req_done <= 1'b0;
            tail_req_done <= 1'b0;
        end else if (state == ST_RD_REQ) begin
            if (state_nxt != ST_RD_REQ) begin
                head_req_done <= 1'b0;
                tail_req_done <= 1'b0;
            end else begin
                if (head_req_fire) begin
                    head_req_done <= 1'b1;
                end
                if (tail_req_fire) begin
                    tail_req_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            head_got <= 1'b0;
            tail_got <= 1'b0;
        end else begin
            if (head_resp_fire) begin
                head_q <= head_rd_resp_data;
            end
            if (tail_resp_fire) begin
                tail_q <= tail_rd_resp_data;
            end
            if (state == ST_RD_RESP) begin
                if (state_nxt != ST_RD_RESP) begin
                    head_got <= 1'b0;
                    tail_got <= 1'b0;
                end else begin
                    if (head_resp_fire) begin
                        head_got <= 1'b1;
                    end
                    if (tail_resp_fire) begin
                        tail_got <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Write channels
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tail_wr_done <= 1'b0;
            buf_wr_done  <= 1'b0;
        end else if (state == ST_WR) begin
            if (state_nxt != ST_WR) begin
                tail_wr_done <= 1'b0;
                buf_wr_done  <= 1'b0;
            end else begin
                if (tail_wr_fire) begin
                    tail_wr_done <= 1'b1;
                end
                if (buf_wr_fire) begin
                    buf_wr_done <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_payload_q_enq_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_payload_q_enq_engine
// Description : Self-checking bench. Instance 0 drops on full, instance 1
//               re-polls on full. Pointer memories and the payload buffer
//               are modelled here; a per-instance monitor checks every
//               meaningful output against queue-occupancy arithmetic on the
//               pointers the bench delivered.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rx_payload_q_enq_engine;

    localparam int FW = 4;
    localparam int QW = 3;
    localparam int EW = 256;
    localparam int PW = QW + 1;
    localparam int AW = FW + QW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          enq_req_val       [2];
    logic [FW-1:0] enq_req_flowid    [2];
    logic [EW-1:0] enq_req_data      [2];
    logic          enq_req_rdy       [2];
    logic          enq_resp_val      [2];
    logic [FW-1:0] enq_resp_flowid   [2];
    logic [PW-1:0] enq_resp_index    [2];
    logic          enq_resp_dropped  [2];
    logic          enq_resp_rdy      [2];
    logic          head_rd_req_val   [2];
    logic [FW-1:0] head_rd_req_addr  [2];
    logic          head_rd_req_rdy   [2];
    logic          head_rd_resp_val  [2];
    logic [PW-1:0] head_rd_resp_data [2];
    logic          head_rd_resp_rdy  [2];
    logic          tail_rd_req_val   [2];
    logic [FW-1:0] tail_rd_req_addr  [2];
    logic          tail_rd_req_rdy   [2];
    logic          tail_rd_resp_val  [2];
    logic [PW-1:0] tail_rd_resp_data [2];
    logic          tail_rd_resp_rdy  [2];
    logic          tail_wr_req_val   [2];
    logic [FW-1:0] tail_wr_req_addr  [2];
    logic [PW-1:0] tail_wr_req_data  [2];
    logic          tail_wr_req_rdy   [2];
    logic          buf_wr_req_val    [2];
    logic [AW-1:0] buf_wr_req_addr   [2];
    logic [EW-1:0] buf_wr_req_data   [2];
    logic          buf_wr_req_rdy    [2];

    // Memory models and response delays (extra cycles beyond latency 1)
    logic [PW-1:0] head_mem [2][16];
    logic [PW-1:0] tail_mem [2][16];
    int            head_dly [2];
    int            tail_dly [2];
    logic [PW-1:0] head_script[$];   // overrides head reads of instance 1

    // Model / observation state
    logic [FW-1:0] cur_flow  [2];
    logic [EW-1:0] cur_data  [2];
    logic [PW-1:0] obs_head  [2];
    logic [PW-1:0] obs_tail  [2];
    int            acc_cyc   [2];
    int            first_resp[2];
    bit            resp_seen [2];
    int            buf_hs    [2];
    int            tail_hs   [2];
    int            rd_head_n [2];
    int            rd_tail_n [2];
    int            n_resp    [2];
    logic [AW-1:0] last_buf_addr [2];
    logic [PW-1:0] last_tail_data[2];
    logic [PW-1:0] last_index    [2];
    logic          last_dropped  [2];
    int            last_lat      [2];
    int            last_bufhs    [2];
    int            last_tailhs   [2];
    int            last_rdpair   [2];

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] head_lookup(input int g, input logic [FW-1:0] a);
        if (g == 1 && head_script.size() != 0) return head_script.pop_front();
        return head_mem[g][a];
    endfunction

    generate
        for (genvar g = 0; g < 2; g++) begin : g_inst
            rx_payload_q_enq_engine #(
                .FLOW_ID_W      (FW),
                .Q_SIZE_W       (QW),
                .ENTRY_W        (EW),
                .DROP_WHEN_FULL ((g == 0) ? 1 : 0)
            ) u_dut (
                .clk               (clk),
                .rst               (rst),
                .enq_req_val       (enq_req_val[g]),
                .enq_req_flowid    (enq_req_flowid[g]),
                .enq_req_data      (enq_req_data[g]),
                .enq_req_rdy       (enq_req_rdy[g]),
                .enq_resp_val      (enq_resp_val[g]),
                .enq_resp_flowid   (enq_resp_flowid[g]),
                .enq_resp_index    (enq_resp_index[g]),
                .enq_resp_dropped  (enq_resp_dropped[g]),
                .enq_resp_rdy      (enq_resp_rdy[g]),
                .head_rd_req_val   (head_rd_req_val[g]),
                .head_rd_req_addr  (head_rd_req_addr[g]),
                .head_rd_req_rdy   (head_rd_req_rdy[g]),
                .head_rd_resp_val  (head_rd_resp_val[g]),
                .head_rd_resp_data (head_rd_resp_data[g]),
                .head_rd_resp_rdy  (head_rd_resp_rdy[g]),
                .tail_rd_req_val   (tail_rd_req_val[g]),
                .tail_rd_req_addr  (tail_rd_req_addr[g]),
                .tail_rd_req_rdy   (tail_rd_req_rdy[g]),
                .tail_rd_resp_val  (tail_rd_resp_val[g]),
                .tail_rd_resp_data (tail_rd_resp_data[g]),
                .tail_rd_resp_rdy  (tail_rd_resp_rdy[g]),
                .tail_wr_req_val   (tail_wr_req_val[g]),
                .tail_wr_req_addr  (tail_wr_req_addr[g]),
                .tail_wr_req_data  (tail_wr_req_data[g]),
                .tail_wr_req_rdy   (tail_wr_req_rdy[g]),
                .buf_wr_req_val    (buf_wr_req_val[g]),
                .buf_wr_req_addr   (buf_wr_req_addr[g]),
                .buf_wr_req_data   (buf_wr_req_data[g]),
                .buf_wr_req_rdy    (buf_wr_req_rdy[g])
            );

            // Head pointer memory: latency 1 plus head_dly extra cycles
            int            hcnt;
            bit            hpend;
            logic [FW-1:0] haddr;
            always @(posedge clk or negedge rst) begin
                if (!rst) begin
                    head_rd_resp_val[g] <= 1'b0;
                    hpend <= 1'b0;
                end else begin
                    if (head_rd_resp_val[g] && head_rd_resp_rdy[g]) head_rd_resp_val[g] <= 1'b0;
                    if (head_rd_req_val[g] && head_rd_req_rdy[g]) begin
                        if (head_dly[g] == 0) begin
                            head_rd_resp_val[g]  <= 1'b1;
                            head_rd_resp_data[g] <= head_lookup(g, head_rd_req_addr[g]);
                        end else begin
                            hpend <= 1'b1;
                            haddr <= head_rd_req_addr[g];
                            hcnt  <= head_dly[g] - 1;
                        end
                    end else if (hpend) begin
                        if (hcnt == 0) begin
                            head_rd_resp_val[g]  <= 1'b1;
                            head_rd_resp_data[g] <= head_lookup(g, haddr);
                            hpend <= 1'b0;
                        end else begin
                            hcnt <= hcnt - 1;
                        end
                    end
                end
            end

            // Tail pointer memory
            int            tcnt;
            bit            tpend;
            logic [FW-1:0] taddr;
            always @(posedge clk or negedge rst) begin
                if (!rst) begin
                    tail_rd_resp_val[g] <= 1'b0;
                    tpend <= 1'b0;
                end else begin
                    if (tail_rd_resp_val[g] && tail_rd_resp_rdy[g]) tail_rd_resp_val[g] <= 1'b0;
                    if (tail_rd_req_val[g] && tail_rd_req_rdy[g]) begin
                        if (tail_dly[g] == 0) begin
                            tail_rd_resp_val[g]  <= 1'b1;
                            tail_rd_resp_data[g] <= tail_mem[g][tail_rd_req_addr[g]];
                        end else begin
                            tpend <= 1'b1;
                            taddr <= tail_rd_req_addr[g];
                            tcnt  <= tail_dly[g] - 1;
                        end
                    end else if (tpend) begin
                        if (tcnt == 0) begin
                            tail_rd_resp_val[g]  <= 1'b1;
                            tail_rd_resp_data[g] <= tail_mem[g][taddr];
                            tpend <= 1'b0;
                        end else begin
                            tcnt <= tcnt - 1;
                        end
                    end
                    if (tail_wr_req_val[g] && tail_wr_req_rdy[g])
                        tail_mem[g][tail_wr_req_addr[g]] <= tail_wr_req_data[g];
                end
            end

            // Monitor / model compare
            always @(negedge clk) begin
                logic [PW-1:0] occ;
                bit            exp_drop;
                if (!rst) begin
                    check("rst_vals", {enq_req_rdy[g], head_rd_req_val[g], tail_rd_req_val[g],
                                       tail_wr_req_val[g], buf_wr_req_val[g], enq_resp_val[g]}, 6'b0);
                    check("rst_resp_fields", {enq_resp_index[g], enq_resp_dropped[g]}, 5'b0);
                    resp_seen[g] = 1'b1;
                end else begin
                    if (enq_req_val[g] && enq_req_rdy[g]) begin
                        cur_flow[g]       = enq_req_flowid[g];
                        cur_data[g]       = enq_req_data[g];
                        acc_cyc[g]        = cyc;
                        resp_seen[g]      = 1'b0;
                        buf_hs[g]         = 0;
                        tail_hs[g]        = 0;
                        rd_head_n[g]      = 0;
                        rd_tail_n[g]      = 0;
                        last_buf_addr[g]  = '1;
                        last_tail_data[g] = '1;
                        last_index[g]     = '1;
                        last_dropped[g]   = 1'bx;
                        last_lat[g]       = -1;
                    end
                    if (head_rd_req_val[g]) begin
                        check("head_rd_addr", head_rd_req_addr[g], cur_flow[g]);
                        if (head_rd_req_rdy[g]) rd_head_n[g]++;
                    end
                    if (tail_rd_req_val[g]) begin
                        check("tail_rd_addr", tail_rd_req_addr[g], cur_flow[g]);
                        if (tail_rd_req_rdy[g]) rd_tail_n[g]++;
                    end
                    if (head_rd_resp_val[g] && head_rd_resp_rdy[g]) obs_head[g] = head_rd_resp_data[g];
                    if (tail_rd_resp_val[g] && tail_rd_resp_rdy[g]) obs_tail[g] = tail_rd_resp_data[g];
                    if (buf_wr_req_val[g]) begin
                        check("buf_wr_addr", buf_wr_req_addr[g], {cur_flow[g], obs_tail[g][QW-1:0]});
                        check("buf_wr_data", buf_wr_req_data[g], cur_data[g]);
                        if (buf_wr_req_rdy[g]) begin
                            buf_hs[g]++;
                            last_buf_addr[g] = buf_wr_req_addr[g];
                        end
                    end
                    if (tail_wr_req_val[g]) begin
                        check("tail_wr_addr", tail_wr_req_addr[g], cur_flow[g]);
                        check("tail_wr_data", tail_wr_req_data[g], PW'(obs_tail[g] + 1));
                        if (tail_wr_req_rdy[g]) begin
                            tail_hs[g]++;
                            last_tail_data[g] = tail_wr_req_data[g];
                        end
                    end
                    if (enq_resp_val[g]) begin
                        // Occupancy of 2**QW entries means the queue is full.
                        occ      = PW'(obs_tail[g] - obs_head[g]);
                        exp_drop = (g == 0) && (occ == PW'(1 << QW));
                        if (!resp_seen[g]) begin
                            resp_seen[g]  = 1'b1;
                            first_resp[g] = cyc;
                        end
                        check("resp_flowid", enq_resp_flowid[g], cur_flow[g]);
                        check("resp_index", enq_resp_index[g], obs_tail[g]);
                        check("resp_dropped", enq_resp_dropped[g], exp_drop);
                        check("resp_while_wr", {buf_wr_req_val[g], tail_wr_req_val[g]}, 2'b0);
                        if (enq_resp_rdy[g]) begin
                            check("buf_wr_count", buf_hs[g], exp_drop ? 0 : 1);
                            check("tail_wr_count", tail_hs[g], exp_drop ? 0 : 1);
                            last_index[g]   = enq_resp_index[g];
                            last_dropped[g] = enq_resp_dropped[g];
                            last_lat[g]     = first_resp[g] - acc_cyc[g];
                            last_bufhs[g]   = buf_hs[g];
                            last_tailhs[g]  = tail_hs[g];
                            last_rdpair[g]  = (rd_head_n[g] == rd_tail_n[g]) ? rd_head_n[g] : -1;
                            n_resp[g]++;
                        end
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_req(input int g, input logic [FW-1:0] f, input logic [EW-1:0] d);
        bit ok = 1'b0;
        @(posedge clk); #1;
        enq_req_val[g]    = 1'b1;
        enq_req_flowid[g] = f;
        enq_req_data[g]   = d;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (enq_req_rdy[g]) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        enq_req_val[g] = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_resp(input int g, input int n0);
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            if (n_resp[g] != n0) begin ok = 1'b1; break; end
        end
        #1;
        if (!ok) check("resp_timeout", 0, 1);
    endtask

    function automatic bit probe(input int sel);
        case (sel)
            0:       return enq_resp_val[0];
            1:       return tail_wr_req_val[0];
            default: return buf_wr_req_val[0];
        endcase
    endfunction

    task automatic wait_probe(input int sel, input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (probe(sel)) begin ok = 1'b1; break; end
        end
        if (!ok) check(name, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n0;
        for (int g = 0; g < 2; g++) begin
            enq_req_val[g] = 1'b0; enq_req_flowid[g] = '0; enq_req_data[g] = '0;
            enq_resp_rdy[g] = 1'b1; head_rd_req_rdy[g] = 1'b1; tail_rd_req_rdy[g] = 1'b1;
            tail_wr_req_rdy[g] = 1'b1; buf_wr_req_rdy[g] = 1'b1;
            head_dly[g] = 0; tail_dly[g] = 0; n_resp[g] = 0;
            for (int a = 0; a < 16; a++) begin
                head_mem[g][a] = '0;
                tail_mem[g][a] = '0;
            end
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // 1: empty queue, minimum latency
        n0 = n_resp[0];
        send_req(0, 4'd3, {8{32'hA5A5_0003}});
        wait_resp(0, n0);
        check("t1_index", last_index[0], 4'd0);
        check("t1_dropped", last_dropped[0], 1'b0);
        check("t1_buf_addr", last_buf_addr[0], 7'h18);
        check("t1_tail_wr", last_tail_data[0], 4'd1);
        check("t1_latency", last_lat[0], 5);
        check("t1_tail_mem", tail_mem[0][3], 4'd1);

        // 2: full queue dropped, response held while consumer stalls
        head_mem[0][5] = 4'b0010; tail_mem[0][5] = 4'b1010;
        enq_resp_rdy[0] = 1'b0;
        n0 = n_resp[0];
        send_req(0, 4'd5, {8{32'h5555_0005}});
        wait_probe(0, "t2_resp_timeout");
        repeat (2) @(posedge clk);
        #1 enq_resp_rdy[0] = 1'b1;
        wait_resp(0, n0);
        check("t2_dropped", last_dropped[0], 1'b1);
        check("t2_index", last_index[0], 4'b1010);
        check("t2_buf_writes", last_bufhs[0], 0);
        check("t2_tail_mem", tail_mem[0][5], 4'b1010);

        // 3: last slot, wrap bit toggles
        head_mem[0][1] = 4'b0001; tail_mem[0][1] = 4'b0111;
        n0 = n_resp[0];
        send_req(0, 4'd1, {8{32'h1234_0001}});
        wait_resp(0, n0);
        check("t3_buf_addr", last_buf_addr[0], 7'b0001_111);
        check("t3_tail_wr", last_tail_data[0], 4'b1000);
        check("t3_index", last_index[0], 4'b0111);
        check("t3_dropped", last_dropped[0], 1'b0);

        // 4: re-poll instance, full for three polls
        head_mem[1][2] = 4'b1011; tail_mem[1][2] = 4'b1011;
        head_script = {4'b0011, 4'b0011, 4'b0011};
        n0 = n_resp[1];
        send_req(1, 4'd2, {8{32'hCAFE_0002}});
        wait_resp(1, n0);
        check("t4_read_pairs", last_rdpair[1], 4);
        check("t4_buf_addr", last_buf_addr[1], 7'h13);
        check("t4_tail_wr", last_tail_data[1], 4'b1100);
        check("t4_index", last_index[1], 4'b1011);
        check("t4_dropped", last_dropped[1], 1'b0);

        // 5: late head response, tail write stalled four cycles
        head_mem[0][6] = 4'b0000; tail_mem[0][6] = 4'b0100;
        head_dly[0] = 3;
        tail_wr_req_rdy[0] = 1'b0;
        n0 = n_resp[0];
        send_req(0, 4'd6, {8{32'hBEEF_0006}});
        wait_probe(1, "t5_tail_wr_timeout");
        repeat (4) @(posedge clk);
        #1 tail_wr_req_rdy[0] = 1'b1;
        wait_resp(0, n0);
        head_dly[0] = 0;
        check("t5_buf_writes", last_bufhs[0], 1);
        check("t5_tail_writes", last_tailhs[0], 1);
        check("t5_buf_addr", last_buf_addr[0], 7'h34);
        check("t5_tail_wr", last_tail_data[0], 4'b0101);
        check("t5_latency", last_lat[0], 12);

        // 6a: reset in the middle of the write phase
        buf_wr_req_rdy[0] = 1'b0; tail_wr_req_rdy[0] = 1'b0;
        send_req(0, 4'd7, {8{32'h7777_0007}});
        wait_probe(2, "t6_wr_timeout");
        @(posedge clk); #1 rst = 1'b0;
        #1 check("t6_wr_rst_vals", {buf_wr_req_val[0], tail_wr_req_val[0], enq_resp_val[0], enq_req_rdy[0]}, 4'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        buf_wr_req_rdy[0] = 1'b1; tail_wr_req_rdy[0] = 1'b1;
        check("t6_tail_mem7", tail_mem[0][7], 4'd0);

        // 6b: reset while the completion is pending
        tail_mem[0][8] = 4'b0011;
        enq_resp_rdy[0] = 1'b0;
        send_req(0, 4'd8, {8{32'h8888_0008}});
        wait_probe(0, "t6_resp_timeout");
        @(posedge clk); #1 rst = 1'b0;
        #1 check("t6_resp_rst", {enq_resp_val[0], enq_resp_index[0], enq_resp_dropped[0]}, 6'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        enq_resp_rdy[0] = 1'b1;

        // 6c: normal request after reset
        n0 = n_resp[0];
        send_req(0, 4'd7, {8{32'h7777_1007}});
        wait_resp(0, n0);
        check("t6_index", last_index[0], 4'd0);
        check("t6_buf_addr", last_buf_addr[0], 7'h38);
        check("t6_tail_wr", last_tail_data[0], 4'd1);
        check("t6_latency", last_lat[0], 5);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
